// File: rtl/get_certificate_request_pkg.sv
// Shared constants, payload types and header builder for the auth requester stages.
package get_certificate_request_pkg;

  localparam int unsigned SIZE_OF_HEADER_IN_BYTES = 4;
  localparam int unsigned SIZE_OF_HEADER_VARS     = SIZE_OF_HEADER_IN_BYTES * 8;
  localparam int unsigned LEN_W                   = 16;
  localparam int unsigned SLOT_W                  = 3;
  localparam int unsigned ERR_W                   = 3;

  localparam logic [7:0] AUTH_PROTO_VER      = 8'h01;
  localparam logic [7:0] MSG_GET_CERTIFICATE = 8'h81;
  localparam logic [7:0] MSG_CERTIFICATE     = 8'h01;
  localparam logic [7:0] MSG_ERROR           = 8'h7F;

  localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
  localparam logic [ERR_W-1:0] ERR_RESPONDER  = 3'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 3'd2;
  localparam logic [ERR_W-1:0] ERR_BAD_LEN    = 3'd3;
  localparam logic [ERR_W-1:0] ERR_UNEXP_TYPE = 3'd4;

  // Byte0 (version) sits in the least significant byte.
  typedef struct packed {
    logic [7:0] param2;
    logic [7:0] param1;
    logic [7:0] msg_type;
    logic [7:0] version;
  } auth_header_t;

  typedef struct packed {
    logic [LEN_W-1:0] req_len;
    logic [LEN_W-1:0] offset;
  } cert_payload_t;

  // GET_CERTIFICATE header for a given slot.
  function automatic auth_header_t build_get_cert_header(input logic [SLOT_W-1:0] slot);
    auth_header_t h;
    h.version  = AUTH_PROTO_VER;
    h.msg_type = MSG_GET_CERTIFICATE;
    h.param1   = 8'(slot);
    h.param2   = 8'h00;
    return h;
  endfunction

endpackage

// File: rtl/get_certificate_request_timer.sv
// Response timer shared by requester stages: counts enabled cycles, flags TIMEOUT-1.
module auth_resp_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign expire_c = (count_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear wins, saturate at the expiry value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && !expire_c) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/get_certificate_request.sv
// Requester sequencer fetching a certificate chain in GET_CERTIFICATE windows.
module get_certificate_request
  import get_certificate_request_pkg::*;
#(
  parameter int unsigned CHUNK_MAX = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           Enable,
  input  logic [SLOT_W-1:0]              slot_id,
  input  logic [LEN_W-1:0]               chain_len,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [SIZE_OF_HEADER_VARS-1:0] header,
  output logic [31:0]                    payload,
  input  logic                           Ack_in,
  input  logic [7:0]                     resp_type,
  input  logic [LEN_W-1:0]               resp_len,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [ERR_W-1:0]               err_code
);

  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE, ST_ERR} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  offset_q, offset_d;
  logic [LEN_W-1:0]  new_off_c, remain_c, req_len_c;
  logic [ERR_W-1:0]  err_code_q, err_code_d;
  logic              req_valid_q, req_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  auth_header_t      header_q, header_d;
  cert_payload_t     payload_q, payload_d;
  logic              timer_clear, timer_en, timer_expire_c;

  auth_resp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .en      (timer_en),
    .expire_c(timer_expire_c)
  );

  // Next state, context and registered-output values decoded from the next state.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    len_d       = len_q;
    offset_d    = offset_q;
    err_code_d  = err_code_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    new_off_c   = offset_q + resp_len;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          slot_d     = slot_id;
          len_d      = chain_len;
          offset_d   = '0;
          err_code_d = ERR_NONE;
          state_d    = (chain_len == '0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (req_valid_q && req_ready) begin
          state_d     = ST_WAIT;
          timer_clear = 1'b1;
        end
      end
      ST_WAIT: begin
        if (Ack_in) begin
          if (resp_type == MSG_ERROR) begin
            state_d    = ST_ERR;
            err_code_d = ERR_RESPONDER;
          end else if (resp_type != MSG_CERTIFICATE) begin
            state_d    = ST_ERR;
            err_code_d = ERR_UNEXP_TYPE;
          end else if ((resp_len == '0) || (resp_len > payload_q.req_len)) begin
            state_d    = ST_ERR;
            err_code_d = ERR_BAD_LEN;
          end else begin
            offset_d = new_off_c;
            state_d  = (new_off_c == len_q) ? ST_DONE : ST_SEND;
          end
        end else if (timer_expire_c) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    remain_c  = len_d - offset_d;
    req_len_c = (remain_c > LEN_W'(CHUNK_MAX)) ? LEN_W'(CHUNK_MAX) : remain_c;

    req_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERR);
    header_d    = header_q;
    payload_d   = payload_q;
    if (state_d == ST_SEND) begin
      header_d          = build_get_cert_header(slot_d);
      payload_d.offset  = offset_d;
      payload_d.req_len = req_len_c;
    end
  end

  // State, context and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      len_q       <= '0;
      offset_q    <= '0;
      err_code_q  <= ERR_NONE;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      header_q    <= '0;
      payload_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      len_q       <= len_d;
      offset_q    <= offset_d;
      err_code_q  <= err_code_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      header_q    <= header_d;
      payload_q   <= payload_d;
    end
  end

  assign req_valid = req_valid_q;
  assign header    = header_q;
  assign payload   = payload_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_get_certificate_request.sv
// Directed plus randomized bench for get_certificate_request with a chunking model.
module tb_get_certificate_request;

  localparam int unsigned CHUNK = 16;
  localparam int unsigned TMO   = 8;

  logic        clk = 1'b0;
  logic        reset, Enable, req_ready, Ack_in;
  logic [2:0]  slot_id;
  logic [15:0] chain_len, resp_len;
  logic [7:0]  resp_type;
  logic        req_valid, busy, done, error;
  logic [31:0] header, payload;
  logic [2:0]  err_code;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  get_certificate_request #(.CHUNK_MAX(CHUNK), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .Enable   (Enable),
    .slot_id  (slot_id),
    .chain_len(chain_len),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .header   (header),
    .payload  (payload),
    .Ack_in   (Ack_in),
    .resp_type(resp_type),
    .resp_len (resp_len),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_hdr(input logic [2:0] s);
    return {8'h00, 5'b0, s, 8'h81, 8'h01};
  endfunction

  function automatic int unsigned chunk_for(input int unsigned rem);
    return (rem < CHUNK) ? rem : CHUNK;
  endfunction

  task automatic start(input logic [2:0] s, input logic [15:0] len);
    Enable    = 1'b1;
    slot_id   = s;
    chain_len = len;
    step();
    Enable    = 1'b0;
  endtask

  // Checks the pending request, applies backpressure with stray Acks, then handshakes.
  task automatic send_req(input logic [2:0] s, input int unsigned off, input int unsigned rq,
                          input int unsigned bp);
    logic [31:0] exp_pl;
    exp_pl = {16'(rq), 16'(off)};
    check("req_valid", 32'(req_valid), 32'd1);
    check("header", header, exp_hdr(s));
    check("payload", payload, exp_pl);
    for (int i = 0; i < int'(bp); i++) begin
      req_ready = 1'b0;
      Ack_in    = 1'b1;
      resp_type = 8'h01;
      resp_len  = 16'(rq);
      step();
      check("bp_valid", 32'(req_valid), 32'd1);
      check("bp_header", header, exp_hdr(s));
      check("bp_payload", payload, exp_pl);
    end
    Ack_in    = 1'b0;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    check("hs_valid_low", 32'(req_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd1);
  endtask

  task automatic answer(input logic [7:0] t, input logic [15:0] r, input int unsigned dly);
    for (int i = 0; i < int'(dly); i++) begin
      step();
      check("wait_no_error", 32'(error), 32'd0);
    end
    Ack_in    = 1'b1;
    resp_type = t;
    resp_len  = r;
    step();
    Ack_in    = 1'b0;
  endtask

  task automatic expect_error(input logic [2:0] code);
    check("err_pulse", 32'(error), 32'd1);
    check("err_code", 32'(err_code), 32'(code));
    check("err_no_req", 32'(req_valid), 32'd0);
    step();
    check("err_pulse_end", 32'(error), 32'd0);
    check("err_busy_low", 32'(busy), 32'd0);
    check("err_code_held", 32'(err_code), 32'(code));
    check("err_no_req2", 32'(req_valid), 32'd0);
  endtask

  // Model: each window is min(CHUNK, remaining); offset advances by each answered length.
  task automatic run_chain(input logic [2:0] s, input int unsigned len, input bit rnd,
                           input int unsigned first_resp, input int unsigned bp0);
    int unsigned off = 0;
    int unsigned rq, r, dly;
    bit first = 1'b1;
    start(s, 16'(len));
    if (len == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_no_req", 32'(req_valid), 32'd0);
      step();
      check("zero_done_end", 32'(done), 32'd0);
      check("zero_no_req2", 32'(req_valid), 32'd0);
      check("zero_busy_low", 32'(busy), 32'd0);
      return;
    end
    while (off < len) begin
      rq = chunk_for(len - off);
      send_req(s, off, rq, rnd ? $urandom_range(0, 3) : (first ? bp0 : 0));
      if (first && first_resp != 0) r = first_resp;
      else if (rnd && $urandom_range(0, 1) == 1) r = $urandom_range(1, rq);
      else r = rq;
      dly = rnd ? $urandom_range(0, TMO - 1) : 1;
      first = 1'b0;
      answer(8'h01, 16'(r), dly);
      off += r;
    end
    check("chain_done", 32'(done), 32'd1);
    check("chain_err_code", 32'(err_code), 32'd0);
    check("chain_no_req", 32'(req_valid), 32'd0);
    check("chain_no_error", 32'(error), 32'd0);
    step();
    check("chain_done_end", 32'(done), 32'd0);
    check("chain_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; Enable = 1'b0; req_ready = 1'b0; Ack_in = 1'b0;
    slot_id = '0; chain_len = '0; resp_type = '0; resp_len = '0;
    step();
    step();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_header", header, 32'd0);
    check("rst_payload", payload, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    reset = 1'b0;

    // Full-chunk fetch: (0,16) (16,16) (32,8) for slot 2.
    run_chain(3'd2, 40, 1'b0, 0, 0);

    // Short first answer moves second window to offset 10.
    run_chain(3'd1, 40, 1'b0, 10, 0);

    // Backpressure for 5 cycles with stray Acks while in SEND.
    run_chain(3'd6, 20, 1'b0, 0, 5);

    // Zero-length chain.
    run_chain(3'd0, 0, 1'b0, 0, 0);

    // Stray Ack and req_ready while idle.
    Ack_in = 1'b1; resp_type = 8'h01; resp_len = 16'd4; req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_stray_busy", 32'(busy), 32'd0);
      check("idle_stray_valid", 32'(req_valid), 32'd0);
      check("idle_stray_done", 32'(done), 32'd0);
    end
    Ack_in = 1'b0; req_ready = 1'b0;

    // Responder ERROR.
    start(3'd3, 16'd40);
    send_req(3'd3, 0, 16, 0);
    answer(8'h7F, 16'd16, 2);
    expect_error(3'd1);

    // Length larger than requested.
    start(3'd3, 16'd40);
    send_req(3'd3, 0, 16, 0);
    answer(8'h01, 16'd17, 0);
    expect_error(3'd3);

    // Zero-length answer.
    start(3'd4, 16'd5);
    send_req(3'd4, 0, 5, 0);
    answer(8'h01, 16'd0, 1);
    expect_error(3'd3);

    // Unexpected message type.
    start(3'd4, 16'd40);
    send_req(3'd4, 0, 16, 0);
    answer(8'h02, 16'd16, 1);
    expect_error(3'd4);

    // Timeout: error exactly TMO cycles after entering WAIT.
    start(3'd7, 16'd40);
    send_req(3'd7, 0, 16, 0);
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      step();
      check("tmo_not_yet", 32'(error), 32'd0);
    end
    step();
    expect_error(3'd2);

    // Ack on the expiry cycle wins over the timeout.
    start(3'd7, 16'd16);
    check("restart_err_clear", 32'(err_code), 32'd0);
    send_req(3'd7, 0, 16, 0);
    answer(8'h01, 16'd16, TMO - 1);
    check("tie_done", 32'(done), 32'd1);
    check("tie_no_error", 32'(error), 32'd0);
    step();

    // Reset mid-WAIT, then restart at offset 0 in the first cycle after reset.
    start(3'd5, 16'd40);
    send_req(3'd5, 0, 16, 0);
    answer(8'h01, 16'd16, 0);
    send_req(3'd5, 16, 16, 0);
    step();
    reset = 1'b1;
    step();
    check("mid_rst_valid", 32'(req_valid), 32'd0);
    check("mid_rst_header", header, 32'd0);
    check("mid_rst_payload", payload, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    run_chain(3'd5, 40, 1'b0, 0, 0);

    // Randomized chains against the model.
    for (int n = 0; n < 25; n++) begin
      run_chain(3'($urandom_range(0, 7)), $urandom_range(1, 100), 1'b1, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
